// File: rtl/uart_frame_proc.sv
// uart_frame_proc: parses SYNC/OP/LEN framed pixel packets from the UART RX FIFO,
// applies a per-pixel op and streams results plus a trailing checksum to the TX FIFO.
module uart_frame_proc #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter logic [7:0] THRESH    = 8'd128,
    parameter logic [7:0] BRIGHT    = 8'd32,
    parameter logic [7:0] ERR_BYTE  = 8'hEE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_empty,
    input  logic [7:0] r_data,
    output logic       rd_uart,
    input  logic       tx_full,
    output logic       wr_uart,
    output logic [7:0] w_data,
    output logic       busy,
    output logic       frame_done,
    output logic       op_err
);
    typedef enum logic [2:0] {IDLE, OP, LEN_H, LEN_L, RD, WR, TRAIL} state_t;
    state_t state, next;
    logic [7:0]  op, csum, result;
    logic [15:0] cnt;
    logic [8:0]  sum9;
    logic        bad, last;
    assign bad  = op > 8'h03;
    assign last = cnt == 16'd1;
    assign sum9 = {1'b0, r_data} + {1'b0, BRIGHT};
    assign result = op == 8'h00 ? r_data :
                    op == 8'h01 ? ~r_data :
                    op == 8'h02 ? (r_data >= THRESH ? 8'hFF : 8'h00) :
                    (sum9[8] ? 8'hFF : sum9[7:0]);
    always_ff @(posedge clk)
        if (reset) state <= IDLE;
        else state <= next;
    always_comb begin
        next = state;
        case (state)
            IDLE:    if (rd_uart && r_data == SYNC_BYTE) next = OP;
            OP:      if (rd_uart) next = LEN_H;
            LEN_H:   if (rd_uart) next = LEN_L;
            LEN_L:   if (rd_uart) next = {cnt[15:8], r_data} == 16'd0 ? TRAIL : RD;
            RD:      if (rd_uart) next = !bad ? WR : last ? TRAIL : RD;
            WR:      if (wr_uart) next = cnt == 16'd0 ? TRAIL : RD;
            TRAIL:   if (wr_uart) next = IDLE;
            default: next = IDLE;
        endcase
    end
    always_comb begin
        busy       = state != IDLE;
        rd_uart    = !rx_empty && (state inside {IDLE, OP, LEN_H, LEN_L, RD});
        wr_uart    = !tx_full && (state inside {WR, TRAIL});
        frame_done = wr_uart && state == TRAIL;
    end
    // w_data doubles as the output register: it carries each result and finally the trailer byte
    always_ff @(posedge clk) begin
        if (reset) begin
            op     <= 8'h00;
            csum   <= 8'h00;
            cnt    <= 16'd0;
            w_data <= 8'h00;
            op_err <= 1'b0;
        end else begin
            op_err <= 1'b0;
            case (state)
                OP: if (rd_uart) begin
                    op     <= r_data;
                    csum   <= 8'h00;
                    op_err <= r_data > 8'h03;
                end
                LEN_H: if (rd_uart) cnt[15:8] <= r_data;
                LEN_L: if (rd_uart) begin
                    cnt[7:0] <= r_data;
                    if ({cnt[15:8], r_data} == 16'd0) w_data <= bad ? ERR_BYTE : csum;
                end
                RD: if (rd_uart) begin
                    cnt    <= cnt - 16'd1;
                    w_data <= !bad ? result : last ? ERR_BYTE : w_data;
                end
                WR: if (wr_uart) begin
                    csum <= csum + w_data;
                    if (cnt == 16'd0) w_data <= csum + w_data;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_frame_proc.sv
// tb_uart_frame_proc: directed and randomized frames with FIFO stalls, checked
// against a byte-level reference model of the frame processor.
module tb_uart_frame_proc;
    logic       clk = 1'b0;
    logic       reset, rx_empty, tx_full, rd_uart, wr_uart, busy, frame_done, op_err;
    logic [7:0] r_data, w_data;
    logic [7:0] pay[$], exp_q[$], rxq[$], txq[$];
    int checks = 0, errors = 0, fd_n, oe_n, rx_stall = 0, tx_stall = 0;
    bit force_full = 1'b0;

    uart_frame_proc dut (
        .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
        .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data), .busy(busy),
        .frame_done(frame_done), .op_err(op_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // drive at negedge, then sample just before the next posedge what the DUT is about to do
    task automatic cycle();
        @(negedge clk);
        rx_empty = rxq.size() == 0 || $urandom_range(99) < rx_stall;
        r_data   = rx_empty ? 8'h00 : rxq[0];
        tx_full  = force_full || $urandom_range(99) < tx_stall;
        #4;
        if (!reset) begin
            if (rd_uart) begin
                if (rx_empty) chk("rd_when_empty", 1, 0);
                else void'(rxq.pop_front());
            end
            if (wr_uart) begin
                if (tx_full) chk("wr_when_full", 1, 0);
                txq.push_back(w_data);
            end
            if (frame_done && !wr_uart) chk("done_without_wr", 1, 0);
            fd_n += int'(frame_done);
            oe_n += int'(op_err);
        end
    endtask

    function automatic void model(input logic [7:0] op);
        int s = 0, r;
        exp_q.delete();
        if (op > 3) begin
            exp_q.push_back(8'hEE);
            return;
        end
        foreach (pay[i]) begin
            int p = int'(pay[i]);
            r = op == 0 ? p : op == 1 ? 255 - p : op == 2 ? (p >= 128 ? 255 : 0) :
                (p + 32 > 255 ? 255 : p + 32);
            exp_q.push_back(8'(r));
            s = (s + r) % 256;
        end
        exp_q.push_back(8'(s));
    endfunction

    task automatic run_frame(input string tag, input logic [7:0] op, input int njunk);
        int n = 0, bound;
        logic [7:0] j;
        rxq.delete(); txq.delete(); fd_n = 0; oe_n = 0;
        repeat (njunk) begin
            j = 8'($urandom);
            rxq.push_back(j == 8'hA5 ? 8'h5A : j);
        end
        rxq.push_back(8'hA5); rxq.push_back(op);
        rxq.push_back(8'(pay.size() >> 8)); rxq.push_back(8'(pay.size()));
        foreach (pay[i]) rxq.push_back(pay[i]);
        bound = 40 * (pay.size() + njunk) + 200;
        cycle();
        while ((rxq.size() != 0 || busy) && n < bound) begin
            cycle();
            n++;
        end
        if (n >= bound) chk({tag, "_timeout"}, 1, 0);
        chk({tag, "_len"}, txq.size(), exp_q.size());
        foreach (exp_q[i]) if (i < txq.size()) chk({tag, "_byte"}, txq[i], exp_q[i]);
        chk({tag, "_done"}, fd_n, 1);
        chk({tag, "_operr"}, oe_n, op > 3 ? 1 : 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        reset = 1'b1; rx_empty = 1'b1; tx_full = 1'b0; r_data = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0); chk("rst_rd", rd_uart, 0); chk("rst_wr", wr_uart, 0);
        chk("rst_wdata", w_data, 0); chk("rst_done", frame_done, 0); chk("rst_operr", op_err, 0);
        reset = 1'b0;

        pay = '{8'h10, 8'h80, 8'hFF}; exp_q = '{8'hEF, 8'h7F, 8'h00, 8'h6E};
        run_frame("inv", 8'h01, 0);
        pay = '{8'h7F, 8'h80}; exp_q = '{8'h00, 8'hFF, 8'hFF};
        run_frame("thr", 8'h02, 0);
        pay = '{8'hF0, 8'h10}; exp_q = '{8'hFF, 8'h30, 8'h2F};
        run_frame("brt", 8'h03, 0);
        pay.delete(); exp_q = '{8'h00};
        run_frame("junk", 8'h00, 2);
        pay = '{8'h11, 8'h22}; exp_q = '{8'hEE};
        run_frame("bad", 8'h07, 0);

        // back-pressure: AA must be held on w_data and pushed exactly once
        rxq = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h55}; txq.delete(); fd_n = 0;
        force_full = 1'b1;
        repeat (6) cycle();
        repeat (20) begin
            cycle();
            chk("hold_wr", wr_uart, 0);
            chk("hold_wdata", w_data, 8'hAA);
        end
        force_full = 1'b0;
        for (int n = 0; n < 20 && busy; n++) cycle();
        chk("hold_len", txq.size(), 2);
        if (txq.size() == 2) begin
            chk("hold_b0", txq[0], 8'hAA);
            chk("hold_b1", txq[1], 8'hAA);
        end
        chk("hold_done", fd_n, 1);

        // reset while in RD mid-frame
        rxq = '{8'hA5, 8'h00, 8'h00, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        txq.delete();
        for (int n = 0; n < 40 && txq.size() < 2; n++) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        rxq.delete();
        cycle();
        chk("mid_busy", busy, 0); chk("mid_rd", rd_uart, 0); chk("mid_wr", wr_uart, 0);
        chk("mid_wdata", w_data, 0); chk("mid_done", frame_done, 0); chk("mid_operr", op_err, 0);
        chk("mid_pushes", txq.size(), 2);
        pay = '{8'h33, 8'hCC}; exp_q = '{8'h33, 8'hCC, 8'hFF};
        run_frame("after_rst", 8'h00, 0);

        for (int f = 0; f < 30; f++) begin
            logic [7:0] op;
            int len;
            op = $urandom_range(4) == 4 ? 8'($urandom_range(255, 4)) : 8'($urandom_range(3));
            len = f % 10 == 9 ? $urandom_range(300, 200) : $urandom_range(12);
            rx_stall = $urandom_range(30);
            tx_stall = $urandom_range(30);
            pay.delete();
            repeat (len) pay.push_back(8'($urandom));
            model(op);
            run_frame("rand", op, $urandom_range(2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_frame_proc.md
Name: uart_frame_proc

Overview:
- Byte-stream image processor between the UART core's RX FIFO read port and TX FIFO write port.
- Parses framed pixel packets from the host, applies a per-pixel operation and streams processed pixels back.
- Appends an 8-bit checksum after each frame.
- All flow control uses the UART FIFO handshake (rx_empty/rd_uart, tx_full/wr_uart).

Parameters:
SYNC_BYTE, 8'hA5, frame start marker
THRESH, 8'd128, threshold level for op 0x02
BRIGHT, 8'd32, saturating add amount for op 0x03
ERR_BYTE, 8'hEE, byte sent instead of checksum for an unknown op

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_empty  in  1  RX FIFO empty
r_data  in  8  RX FIFO head byte; valid whenever rx_empty=0
rd_uart  out  1  one-cycle pop of RX FIFO
tx_full  in  1  TX FIFO full
wr_uart  out  1  one-cycle push to TX FIFO
w_data  out  8  byte pushed with wr_uart
busy  out  1  high in any state except IDLE
frame_done  out  1  one-cycle pulse when the trailer byte is pushed
op_err  out  1  one-cycle pulse when an unknown op is latched

Behaviour:
- Single clock domain on clk.
- Reset is synchronous and active-high, named reset.
- Reset values: state=IDLE; rd_uart, wr_uart, frame_done, op_err, busy all 0; w_data=0; checksum, length and op registers 0.
- Reset mid-frame aborts the frame immediately. Nothing further is pushed, and bytes already in the FIFOs are untouched.
- Frame format: SYNC_BYTE, OP, LEN_H, LEN_L, then N=LEN payload bytes (16-bit, big-endian).
- RX read rule: r_data is sampled in the same cycle rd_uart=1. rd_uart is asserted only when rx_empty=0 and the state accepts a byte.
- TX write rule: wr_uart is asserted only when tx_full=0. w_data is held stable until the push happens.
- FSM states:
  - IDLE: pop a byte when available. If the byte equals SYNC_BYTE, go to OP; any other value is discarded and the FSM stays in IDLE.
  - OP: pop the op byte and latch it. Clear the checksum. If op > 0x03, pulse op_err in the next cycle and set a bad flag. Go to LEN_H.
  - LEN_H, LEN_L: pop one byte each and latch the length. After LEN_L: if N=0, go to TRAIL; otherwise go to RD.
  - RD: pop a payload byte, compute the result into the output register and decrement the remaining count.
    - If the bad flag is set, go to RD again, or to TRAIL when the count reaches 0.
    - Otherwise go to WR.
  - WR: push the output register when tx_full=0 and add it to the checksum (mod 256). Then go to RD, or to TRAIL if the remaining count is 0.
  - TRAIL: push the checksum (or ERR_BYTE if bad). Pulse frame_done in the same cycle as wr_uart. Return to IDLE.
- Ops:
  - 0x00: pass-through.
  - 0x01: invert (~p).
  - 0x02: 8'hFF if p>=THRESH, else 8'h00.
  - 0x03: min(p+BRIGHT, 255), computed with a 9-bit sum and saturated.
- Throughput: at most one payload byte per 2 clocks (RD then WR). Each payload byte is pushed 1 cycle after its pop when tx_full=0.
- Stalls:
  - rx_empty=1 holds the FSM in its current state with rd_uart=0.
  - tx_full=1 holds WR/TRAIL with wr_uart=0 and w_data unchanged.
- Count wrap: N=16'hFFFF is processed in full. The counter must not underflow.
- A SYNC_BYTE value inside the header or payload is treated as data; there is no resync.

Test Plan:
- Frame A5 01 00 03 10 80 FF, with FIFOs never blocking -> TX receives EF 7F 00 6E; frame_done pulses once; busy returns to 0.
- Frame A5 02 00 02 7F 80 with THRESH=128 -> TX receives 00 FF FF; op 03 with payload F0 10 and BRIGHT=32 -> TX receives FF 30 2F.
- Junk bytes 00 13 before A5 00 00 00 -> junk discarded; TX receives only 00 (N=0 checksum); no payload pushes.
- Unknown op: A5 07 00 02 11 22 -> op_err pulses once; both payload bytes popped; TX receives only EE.
- Hold tx_full=1 for 20 cycles during WR of op-01 frame payload 55 -> wr_uart stays 0 and w_data stays AA throughout. After release, AA is pushed exactly once.
- Inject reset while in RD mid-frame -> next cycle all outputs are 0 and state is IDLE; a following clean frame processes correctly.
